// File: rtl/tia_pkg.sv
// Shared definitions for the TIA playfield cells: mode encoding and default data width.
package tia_pkg;

    localparam int unsigned DEFAULT_WIDTH = 1;

    typedef enum logic [1:0] {
        MODE_HOLD     = 2'd0,
        MODE_FOLLOW   = 2'd1,
        MODE_CONFLICT = 2'd2
    } tia_mode_e;

    // Logical && means an X/Z control never selects FOLLOW or CONFLICT; it falls through to HOLD.
    function automatic tia_mode_e decode_mode(input logic follow, input logic latch);
        tia_mode_e mode;
        mode = MODE_HOLD;
        if (follow && latch) begin
            mode = MODE_CONFLICT;
        end else if (follow && !latch) begin
            mode = MODE_FOLLOW;
        end
        return mode;
    endfunction

endpackage

// File: rtl/tia_l_latch.sv
// Two-phase (L1/L2) transparent latch cell with a registered conflict pulse and a sticky error flag.
module tia_l_latch
    import tia_pkg::*;
#(
    parameter int unsigned           WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i,
    input  logic             follow,
    input  logic             latch,
    input  logic             clr_err,
    output logic [WIDTH-1:0] o,
    output logic             err,
    output logic             err_sticky
);

    tia_mode_e        mode;
    logic [WIDTH-1:0] q_d, q_q;
    logic             err_d, err_q;
    logic             err_sticky_d, err_sticky_q;

    assign mode = decode_mode(follow, latch);

    always_comb begin
        q_d          = q_q;
        err_d        = 1'b0;
        err_sticky_d = err_sticky_q;
        if (clr_err) begin
            err_sticky_d = 1'b0;
        end
        unique case (mode)
            MODE_FOLLOW: q_d = i;
            // A new conflict outranks a coincident clear.
            MODE_CONFLICT: begin
                err_d        = 1'b1;
                err_sticky_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q          <= RESET_VAL;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            q_q          <= q_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    // Transparent path is combinational; reset forces RESET_VAL even when following.
    always_comb begin
        o = q_q;
        if (!rst_n) begin
            o = RESET_VAL;
        end else if (mode == MODE_FOLLOW) begin
            o = i;
        end
    end

    assign err        = err_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_tia_l_latch.sv
// Self-checking bench for tia_l_latch: directed scenarios plus a randomized run against a cycle model.
module tb_tia_l_latch;

    logic       clk;
    logic       rst_n;
    logic [7:0] i8;
    logic       follow, latch, clr_err;
    logic [7:0] o8;
    logic       o1;
    logic       err8, err_sticky8, err1, err_sticky1;

    int n_cmp;
    int n_fail;

    // Reference model state: stored word, one-cycle error pulse, sticky flag.
    logic [7:0] m_q;
    logic       m_err;
    logic       m_st;

    tia_l_latch #(.WIDTH(8), .RESET_VAL(8'h00)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i          (i8),
        .follow     (follow),
        .latch      (latch),
        .clr_err    (clr_err),
        .o          (o8),
        .err        (err8),
        .err_sticky (err_sticky8)
    );

    tia_l_latch u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i          (i8[0]),
        .follow     (follow),
        .latch      (latch),
        .clr_err    (clr_err),
        .o          (o1),
        .err        (err1),
        .err_sticky (err_sticky1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_o();
        if (!rst_n) return 8'h00;
        if (follow == 1'b1 && latch == 1'b0) return i8;
        return m_q;
    endfunction

    // Advance one rising edge, update the model from the inputs seen at that edge, settle 1 time unit.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m_q = 8'h00; m_err = 1'b0; m_st = 1'b0;
        end else begin
            if (follow && !latch) m_q = i8;
            m_err = follow && latch;
            m_st  = (follow && latch) ? 1'b1 : (clr_err ? 1'b0 : m_st);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; follow = 1'b1; latch = 1'b0; clr_err = 1'b0; i8 = 8'hFF;
        m_q = 8'h00; m_err = 1'b0; m_st = 1'b0;
        #3;
        n_cmp++; if (o8 !== 8'h00) begin n_fail++; $display("FAIL reset_o8 got %h want 00", o8); end
        n_cmp++; if (o1 !== 1'b0) begin n_fail++; $display("FAIL reset_o1 got %b want 0", o1); end
        n_cmp++; if (err_sticky8 !== 1'b0 || err8 !== 1'b0) begin
            n_fail++; $display("FAIL reset_err got %b%b want 00", err8, err_sticky8); end
        tick();
        rst_n = 1'b1;
        tick();
        follow = 1'b0;
        #1;
        n_cmp++; if (o8 !== 8'hFF) begin n_fail++; $display("FAIL reset_release_o8 got %h want ff", o8); end
        n_cmp++; if (o1 !== 1'b1) begin n_fail++; $display("FAIL reset_release_o1 got %b want 1", o1); end
    endtask

    task automatic test_hold();
        follow = 1'b1; latch = 1'b0; i8 = 8'hA5;
        tick();
        follow = 1'b0; latch = 1'b1; i8 = 8'h00;
        #1;
        n_cmp++; if (o8 !== 8'hA5) begin n_fail++; $display("FAIL hold_o8 got %h want a5", o8); end
        n_cmp++; if (o1 !== 1'b1) begin n_fail++; $display("FAIL hold_o1 got %b want 1", o1); end
        for (int k = 0; k < 5; k++) begin
            i8 = ~i8;
            tick();
            n_cmp++; if (o8 !== 8'hA5 || o1 !== 1'b1) begin
                n_fail++; $display("FAIL hold_toggle%0d got %h/%b want a5/1", k, o8, o1); end
        end
        latch = 1'b0;
        tick();
        n_cmp++; if (o8 !== 8'hA5) begin n_fail++; $display("FAIL idle_retain got %h want a5", o8); end
    endtask

    task automatic test_transparent();
        follow = 1'b1; latch = 1'b0; i8 = 8'h00;
        tick();
        n_cmp++; if (o1 !== 1'b0) begin n_fail++; $display("FAIL transp_pre got %b want 0", o1); end
        #2 i8 = 8'h3D;
        #1;
        n_cmp++; if (o8 !== 8'h3D) begin n_fail++; $display("FAIL transp_mid_o8 got %h want 3d", o8); end
        n_cmp++; if (o1 !== 1'b1) begin n_fail++; $display("FAIL transp_mid_o1 got %b want 1", o1); end
    endtask

    task automatic test_conflict();
        follow = 1'b1; latch = 1'b0; i8 = 8'h5A;
        tick();
        follow = 1'b1; latch = 1'b1; i8 = 8'hFF;
        #1;
        n_cmp++; if (o8 !== 8'h5A) begin n_fail++; $display("FAIL conflict_hold got %h want 5a", o8); end
        n_cmp++; if (err8 !== 1'b0) begin n_fail++; $display("FAIL conflict_err_early got %b want 0", err8); end
        tick();
        follow = 1'b0; latch = 1'b1;
        n_cmp++; if (err8 !== 1'b1 || err1 !== 1'b1) begin
            n_fail++; $display("FAIL conflict_err got %b/%b want 1/1", err8, err1); end
        n_cmp++; if (err_sticky8 !== 1'b1) begin n_fail++; $display("FAIL conflict_sticky got %b want 1", err_sticky8); end
        n_cmp++; if (o8 !== 8'h5A) begin n_fail++; $display("FAIL conflict_after got %h want 5a", o8); end
        tick();
        n_cmp++; if (err8 !== 1'b0 || err_sticky8 !== 1'b1) begin
            n_fail++; $display("FAIL conflict_pulse_end got %b/%b want 0/1", err8, err_sticky8); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_cmp++; if (err_sticky8 !== 1'b0) begin n_fail++; $display("FAIL clr_sticky got %b want 0", err_sticky8); end
        follow = 1'b1; latch = 1'b1; clr_err = 1'b1;
        tick();
        follow = 1'b0; clr_err = 1'b0;
        n_cmp++; if (err_sticky8 !== 1'b1 || err8 !== 1'b1) begin
            n_fail++; $display("FAIL set_beats_clr got %b/%b want 1/1", err8, err_sticky8); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic test_async_reset();
        follow = 1'b1; latch = 1'b0; i8 = 8'hFF;
        tick();
        follow = 1'b0; latch = 1'b1;
        #2 rst_n = 1'b0;
        m_q = 8'h00; m_err = 1'b0; m_st = 1'b0;
        #1;
        n_cmp++; if (o8 !== 8'h00 || o1 !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_o got %h/%b want 00/0", o8, o1); end
        #1 rst_n = 1'b1;
        #1;
        n_cmp++; if (o8 !== 8'h00) begin n_fail++; $display("FAIL async_reset_q got %h want 00", o8); end
        tick();
        follow = 1'b1; latch = 1'b0; i8 = 8'h77;
        tick();
        #1 rst_n = 1'b0;
        m_q = 8'h00; m_err = 1'b0; m_st = 1'b0;
        #1;
        n_cmp++; if (o8 !== 8'h00) begin n_fail++; $display("FAIL reset_mid_follow got %h want 00", o8); end
        #1 rst_n = 1'b1; follow = 1'b0;
        #1;
        n_cmp++; if (o8 !== 8'h00) begin n_fail++; $display("FAIL reset_discard got %h want 00", o8); end
        tick();
    endtask

    task automatic test_random();
        logic [7:0] exp_o;
        for (int k = 0; k < 300; k++) begin
            i8      = 8'($urandom);
            follow  = 1'($urandom);
            latch   = 1'($urandom_range(0, 3) == 0);
            clr_err = 1'($urandom_range(0, 7) == 0);
            #1;
            exp_o = model_o();
            n_cmp++; if (o8 !== exp_o || o1 !== exp_o[0]) begin
                n_fail++; $display("FAIL rand_o[%0d] got %h/%b want %h", k, o8, o1, exp_o); end
            if (k % 4 == 1) begin
                i8 = 8'($urandom);
                #1;
                exp_o = model_o();
                n_cmp++; if (o8 !== exp_o) begin
                    n_fail++; $display("FAIL rand_mid[%0d] got %h want %h", k, o8, exp_o); end
            end
            tick();
            n_cmp++; if (err8 !== m_err || err_sticky8 !== m_st || err1 !== m_err || err_sticky1 !== m_st) begin
                n_fail++; $display("FAIL rand_err[%0d] got %b%b/%b%b want %b%b",
                                   k, err8, err_sticky8, err1, err_sticky1, m_err, m_st); end
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        test_reset();
        test_hold();
        test_transparent();
        test_conflict();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
